// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg -- shared state encoding and word size for the word-copy DMA.
// Revision 1.0
`default_nettype none

package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

`default_nettype wire

// File: rtl/mem_copy_dma.sv
// mem_copy_dma -- copies len 32-bit words from src to dst over a single-port memory.
// Revision 1.0
`default_nettype none

module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter bit DUMP_ON_DONE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_createdump
);

  state_t      state;
  state_t      next_state;
  logic [31:0] cur_src;
  logic [31:0] cur_dst;
  logic [15:0] remaining;
  logic [31:0] buffer;
  logic        err_flag;
  logic        access_en;
  logic        misaligned;

  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    busy           = 1'b0;
    done           = 1'b0;
    access_en      = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = 32'd0;
    mem_data_in    = 32'd0;
    mem_createdump = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned || (len == 16'd0)) begin
            next_state = DONE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ: begin
        busy       = 1'b1;
        access_en  = 1'b1;
        mem_addr   = cur_src;
        next_state = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        access_en   = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = cur_dst;
        mem_data_in = buffer;
        next_state  = (remaining == 16'd1) ? DONE : READ;
      end
      DONE: begin
        done           = 1'b1;
        mem_createdump = DUMP_ON_DONE;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Reset squelches the access in the same cycle so an aborted copy never commits the pending write.
  assign mem_enable = access_en & ~rst;
  assign err        = err_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_src   <= 32'd0;
      cur_dst   <= 32'd0;
      remaining <= 16'd0;
      buffer    <= 32'd0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= len;
            err_flag  <= misaligned;
          end
        end
        READ: begin
          buffer <= mem_data_out;
        end
        WRITE: begin
          cur_src   <= cur_src + WORD_BYTES;
          cur_dst   <= cur_dst + WORD_BYTES;
          remaining <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma -- randomized self-checking bench with a word-level copy reference model.
// Revision 1.0
`default_nettype none

module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_createdump;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] rd_word = 32'd0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  mem_copy_dma #(.DUMP_ON_DONE(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .mem_enable    (mem_enable),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_createdump(mem_createdump)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'd0;
  endfunction

  // Memory: combinational read, write on the rising edge.
  always @(negedge clk) rd_word = tb_rd(mem_addr);
  assign mem_data_out = (mem_enable && !mem_wr) ? rd_word : 32'd0;
  always @(posedge clk) if (mem_enable && mem_wr) mem[mem_addr] = mem_data_in;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a]     = v;
    exp_mem[a] = v;
  endtask

  // Caller is at a negedge in IDLE; returns at the negedge of the IDLE cycle after done.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input bit hold);
    op_t         ops[$];
    op_t         op;
    logic        err_e;
    int          lat;
    logic [31:0] v;
    err_e = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    if (!err_e) begin
      for (int i = 0; i < int'(n); i++) begin
        v = model_rd(s + 32'(4 * i));
        ops.push_back('{wr: 1'b0, addr: s + 32'(4 * i), data: 32'd0});
        ops.push_back('{wr: 1'b1, addr: d + 32'(4 * i), data: v});
        exp_mem[d + 32'(4 * i)] = v;
      end
    end
    lat = (err_e || n == 16'd0) ? 1 : 2 * int'(n) + 1;
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = n;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      check_eq("err", {31'd0, err}, {31'd0, err_e});
      if (k < lat) begin
        op = ops.pop_front();
        check_eq("busy", {31'd0, busy}, 32'd1);
        check_eq("done_early", {31'd0, done}, 32'd0);
        check_eq("mem_enable", {31'd0, mem_enable}, 32'd1);
        check_eq("mem_wr", {31'd0, mem_wr}, {31'd0, op.wr});
        check_eq("mem_addr", mem_addr, op.addr);
        if (op.wr) check_eq("mem_data_in", mem_data_in, op.data);
        check_eq("dump_early", {31'd0, mem_createdump}, 32'd0);
      end else begin
        check_eq("done", {31'd0, done}, 32'd1);
        check_eq("busy_done", {31'd0, busy}, 32'd0);
        check_eq("enable_done", {31'd0, mem_enable}, 32'd0);
        check_eq("wr_done", {31'd0, mem_wr}, 32'd0);
        check_eq("data_in_done", mem_data_in, 32'd0);
        check_eq("dump_done", {31'd0, mem_createdump}, 32'd1);
      end
    end
    @(negedge clk);
    check_eq("done_idle", {31'd0, done}, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
    check_eq("enable_idle", {31'd0, mem_enable}, 32'd0);
    check_eq("dump_idle", {31'd0, mem_createdump}, 32'd0);
    check_eq("err_held", {31'd0, err}, {31'd0, err_e});
    if (!err_e) begin
      for (int i = 0; i < int'(n); i++)
        check_eq("dst_word", tb_rd(d + 32'(4 * i)), model_rd(d + 32'(4 * i)));
    end
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] w0;
    rst      = 1'b1;
    start    = 1'b0;
    src_addr = 32'd0;
    dst_addr = 32'd0;
    len      = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_enable", {31'd0, mem_enable}, 32'd0);
    check_eq("rst_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_data_in", mem_data_in, 32'd0);
    check_eq("rst_dump", {31'd0, mem_createdump}, 32'd0);

    // Basic copy
    for (int i = 0; i < 3; i++) preload(32'h100 + 32'(4 * i), $urandom);
    run_copy(32'h100, 32'h200, 16'd3, 1'b0);

    // Zero length, then misaligned followed by an aligned request
    run_copy(32'h100, 32'h200, 16'd0, 1'b0);
    run_copy(32'h102, 32'h200, 16'd2, 1'b0);
    run_copy(32'h104, 32'h20C, 16'd1, 1'b0);

    // Reset during the second WRITE of a 4-word copy
    for (int i = 0; i < 4; i++) begin
      preload(32'h300 + 32'(4 * i), $urandom);
      preload(32'h400 + 32'(4 * i), 32'hDEAD0400 + 32'(4 * i));
    end
    start = 1'b1; src_addr = 32'h300; dst_addr = 32'h400; len = 16'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_in_write", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_enable", {31'd0, mem_enable}, 32'd0);
    @(negedge clk);
    check_eq("abort_no_done", {31'd0, done}, 32'd0);
    w0 = model_rd(32'h300);
    exp_mem[32'h400] = w0;
    check_eq("abort_word0", tb_rd(32'h400), w0);
    check_eq("abort_word1", tb_rd(32'h404), 32'hDEAD0404);

    // start held through a copy; the next request lands in the IDLE cycle after done
    for (int i = 0; i < 2; i++) preload(32'h500 + 32'(4 * i), $urandom);
    run_copy(32'h500, 32'h540, 16'd2, 1'b1);
    run_copy(32'h540, 32'h580, 16'd2, 1'b0);

    // Source address wraps past the top of the address space
    preload(32'hFFFFFFFC, $urandom);
    preload(32'h00000000, $urandom);
    run_copy(32'hFFFFFFFC, 32'h600, 16'd2, 1'b0);

    // Randomized copies in a small region, overlaps included
    for (int i = 0; i < 64; i++) preload(32'h800 + 32'(4 * i), $urandom);
    for (int t = 0; t < 25; t++) begin
      s = 32'h800 + 32'(4 * $urandom_range(0, 16));
      d = 32'h800 + 32'(4 * $urandom_range(0, 16));
      if ($urandom_range(0, 7) == 0) s = s + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d = d + 32'($urandom_range(1, 3));
      run_copy(s, d, 16'($urandom_range(0, 6)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
